if_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core. Holds the PC and

---
 rtl/if_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register; fetches one word per cycle when memory is ready, ID updates one edge after acceptance.
// Wait states hold IMemAddr; a word that arrives while ID is stalled is parked; redirects during a fetch finish that fetch, then discard it.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCEn,
  input  logic        IF_ID_En,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  output logic [31:0] Instr_ID,
  output logic [31:0] PCPlus4_ID,
  output logic        Valid_ID,
  output logic        Stall_IF
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  logic        redirect;
  logic        consume;
  logic        word_avail;
  logic [31:0] target;
  logic [31:0] word;
  logic [31:0] pc_plus4;

  always_comb begin
    redirect   = (BranchTaken | JumpTaken) & PCEn;
    target     = BranchTaken ? BranchTarget : JumpTarget;
    consume    = PCEn & IF_ID_En;
    word_avail = ((state_q == S_REQ) && IMemReady) || (state_q == S_HOLD);
    word       = (state_q == S_HOLD) ? buf_q : IMemRdata;
    pc_plus4   = pc_q + 32'd4;

    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    buf_d      = buf_q;
    instr_d    = instr_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (IMemReady) begin
          if (redirect) begin
            pc_d = target;
          end else if (consume) begin
            pc_d = pc_plus4;
          end else begin
            buf_d   = IMemRdata;
            state_d = S_HOLD;
          end
        end else if (redirect) begin
          pend_tgt_d = target;
          state_d    = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (consume) begin
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // The in-flight request must complete; a newer redirect replaces the pending target.
        if (redirect) begin
          pend_tgt_d = target;
        end
        if (IMemReady) begin
          pc_d    = redirect ? target : pend_tgt_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ) || (state_d == S_DROP);

    if (IF_ID_En) begin
      if (word_avail && consume && !redirect) begin
        instr_d = word;
        pcp4_d  = pc_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = 32'h0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      pend_tgt_q <= 32'h0;
      buf_q      <= 32'h0;
      instr_q    <= 32'h0;
      pcp4_q     <= 32'h0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
    end
  end

  assign IMemReq    = req_q;
  assign IMemAddr   = pc_q;
  assign Instr_ID   = instr_q;
  assign PCPlus4_ID = pcp4_q;
  assign Valid_ID   = valid_q;
  assign Stall_IF   = ~word_avail;

endmodule
